// File: rtl/cache_mem_arbiter_if.sv
// ============================================================================
// Module   : cache_mem_arbiter_if
// Brief    : Cache-side and memory-side bus bundle for cache_mem_arbiter.
//            Statistics counters exist only when ARB_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_ack;
    logic [DATA_W-1:0] ic_rdata;
    logic              dc_req;
    logic              dc_wr;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_ack;
    logic [DATA_W-1:0] dc_rdata;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
`ifdef ARB_STATS_EN
    logic [15:0]       ic_gnt_cnt;
    logic [15:0]       dc_gnt_cnt;
    logic [15:0]       conflict_cnt;
`endif

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_wr, dc_addr, dc_wdata, mem_rdata,
        output ic_ack, ic_rdata, dc_ack, dc_rdata,
               mem_en, mem_wr, mem_addr, mem_wdata, busy
`ifdef ARB_STATS_EN
        , output ic_gnt_cnt, dc_gnt_cnt, conflict_cnt
`endif
    );

    modport master (
        output ic_req, ic_addr, dc_req, dc_wr, dc_addr, dc_wdata, mem_rdata,
        input  ic_ack, ic_rdata, dc_ack, dc_rdata,
               mem_en, mem_wr, mem_addr, mem_wdata, busy
`ifdef ARB_STATS_EN
        , input ic_gnt_cnt, dc_gnt_cnt, conflict_cnt
`endif
    );
endinterface

`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
// ============================================================================
// Module   : cache_mem_arbiter
// Brief    : One-at-a-time arbiter of I/D cache misses onto a fixed-latency
//            memory port; D has priority, bounded by a starvation counter.
//            Define ARB_STATS_EN to add saturating grant/conflict counters.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cache_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 4,
    parameter int STARVE_MAX = 3
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    cache_mem_arbiter_if.slave  bus
);
    localparam int         c_CNT_W      = $clog2(MEM_LAT + 1);
    localparam logic [2:0] c_STARVE_MAX = 3'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_ownerI;
    logic               r_wr;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_starveCnt;
    logic               r_icAck;
    logic               r_dcAck;
    logic [DATA_W-1:0]  r_icRdata;
    logic [DATA_W-1:0]  r_dcRdata;
    logic               r_memEn;
    logic               r_memWr;
    logic [ADDR_W-1:0]  r_memAddr;
    logic [DATA_W-1:0]  r_memWdata;
    logic               r_busy;

    logic w_anyReq;
    logic w_bothReq;
    logic w_grantI;

    assign w_anyReq  = bus.ic_req | bus.dc_req;
    assign w_bothReq = bus.ic_req & bus.dc_req;
    // I wins when alone, or when D has already won STARVE_MAX contested rounds.
    assign w_grantI  = bus.ic_req & (~bus.dc_req | (r_starveCnt == c_STARVE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ownerI    <= 1'b0;
            r_wr        <= 1'b0;
            r_cnt       <= '0;
            r_starveCnt <= '0;
            r_icAck     <= 1'b0;
            r_dcAck     <= 1'b0;
            r_icRdata   <= '0;
            r_dcRdata   <= '0;
            r_memEn     <= 1'b0;
            r_memWr     <= 1'b0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_anyReq) begin
                        // The memory-port registers double as the latched request copy.
                        r_ownerI   <= w_grantI;
                        r_wr       <= w_grantI ? 1'b0 : bus.dc_wr;
                        r_memEn    <= 1'b1;
                        r_memWr    <= w_grantI ? 1'b0 : bus.dc_wr;
                        r_memAddr  <= w_grantI ? bus.ic_addr : bus.dc_addr;
                        r_memWdata <= w_grantI ? '0 : bus.dc_wdata;
                        r_busy     <= 1'b1;
                        r_state    <= ST_ISSUE;
                        if (w_grantI) begin
                            r_starveCnt <= '0;
                        end else if (w_bothReq && (r_starveCnt != c_STARVE_MAX)) begin
                            r_starveCnt <= r_starveCnt + 3'd1;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_memEn    <= 1'b0;
                    r_memWr    <= 1'b0;
                    r_memAddr  <= '0;
                    r_memWdata <= '0;
                    r_cnt      <= c_CNT_W'(MEM_LAT);
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == c_CNT_W'(1)) begin
                        if (!r_wr) begin
                            if (r_ownerI) r_icRdata <= bus.mem_rdata;
                            else          r_dcRdata <= bus.mem_rdata;
                        end
                        r_icAck <= r_ownerI;
                        r_dcAck <= ~r_ownerI;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_icAck <= 1'b0;
                    r_dcAck <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ic_ack    = r_icAck;
    assign bus.ic_rdata  = r_icRdata;
    assign bus.dc_ack    = r_dcAck;
    assign bus.dc_rdata  = r_dcRdata;
    assign bus.mem_en    = r_memEn;
    assign bus.mem_wr    = r_memWr;
    assign bus.mem_addr  = r_memAddr;
    assign bus.mem_wdata = r_memWdata;
    assign bus.busy      = r_busy;

`ifdef ARB_STATS_EN
    logic [15:0] r_icGntCnt;
    logic [15:0] r_dcGntCnt;
    logic [15:0] r_conflictCnt;
    logic        w_idle;

    assign w_idle = (r_state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_icGntCnt    <= '0;
            r_dcGntCnt    <= '0;
            r_conflictCnt <= '0;
        end else begin
            if (w_idle && w_anyReq && w_grantI && (r_icGntCnt != 16'hFFFF))
                r_icGntCnt <= r_icGntCnt + 16'd1;
            if (w_idle && w_anyReq && !w_grantI && (r_dcGntCnt != 16'hFFFF))
                r_dcGntCnt <= r_dcGntCnt + 16'd1;
            if (w_idle && w_bothReq && (r_conflictCnt != 16'hFFFF))
                r_conflictCnt <= r_conflictCnt + 16'd1;
        end
    end

    assign bus.ic_gnt_cnt   = r_icGntCnt;
    assign bus.dc_gnt_cnt   = r_dcGntCnt;
    assign bus.conflict_cnt = r_conflictCnt;
`endif
endmodule

`default_nettype wire
